systolic_mac_array: RTL and testbench
=====================================

SYSTOLIC_MAC_ARRAY -- requirements
Module: systolic_mac_array

Interface
REQ-001 SHALL provide parameter N_PE, default 8: number of processing elements in the linear chain (>=1).
REQ-002 SHALL provide parameter DATA_W, default 16: signed operand width.
REQ-003 SHALL provide parameter ACC_W, default 40: signed accumulator and result width (>= 2*DATA_W).
REQ-004 SHALL provide parameter LEN_W, default 16: width of the vector-length field.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle job request; honoured only in IDLE.
REQ-008 len  input  LEN_W  number of input beats K for the job, sampled with start.
REQ-009 in_valid / in_ready  input / output  1 / 1  input beat handshake.
REQ-010 in_x  input  DATA_W  signed streamed operand x[k].
REQ-011 in_w  input  N_PE*DATA_W  signed top row t[k][0..N_PE-1]; slice i is bits [i*DATA_W +: DATA_W].
REQ-012 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-013 out_data  output  ACC_W  signed result y[i].
REQ-014 out_last  output  1  high with the y[N_PE-1] beat.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse the cycle after the final result handshake.

Function
REQ-017 SHALL compute y[i] = sum over k=0..K-1 of x[k]*t[k][i], i = 0..N_PE-1.
REQ-018 FSM states: IDLE, FEED, FLUSH, DRAIN.
REQ-019 IDLE->FEED on start with len>0; IDLE->DRAIN on start with len=0; all accumulators clear to 0 on start acceptance.
REQ-020 in_ready = 1 only in FEED; a beat transfers when in_valid & in_ready; exactly K beats accepted, then FEED->FLUSH.
REQ-021 x travels PE0 to PE(N_PE-1), one PE per cycle; t[k][i] SHALL be skew-delayed i cycles so PE i pairs x[k] with t[k][i].
REQ-022 Each x carries a valid tag; cycles without a transfer inject bubbles that SHALL NOT modify any accumulator.
REQ-023 Beat accepted at edge T SHALL update PE i's accumulator at edge T+i.
REQ-024 FLUSH lasts N_PE-1 cycles (0 when N_PE=1), then goes to DRAIN; the first out_valid is exactly N_PE cycles after the final acceptance cycle.
REQ-025 DRAIN: results shift out toward PE0 in order y[0], y[1], ..., y[N_PE-1]; the chain advances only on out_valid & out_ready.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-027 After the y[N_PE-1] handshake: go to IDLE, pulse done for one cycle, and deassert out_valid.
REQ-028 Product: full 2*DATA_W signed, sign-extended to ACC_W; the default sum wraps modulo 2^ACC_W.
REQ-029 start outside IDLE SHALL be ignored with no effect; in_w is ignored when no beat transfers.

Reset
REQ-030 reset SHALL immediately force IDLE, clear all accumulators, skew buffers and valid tags, and drive in_ready, out_valid, out_last, busy and done to 0 and out_data to 0.
REQ-031 reset mid-job SHALL abandon the job; no partial result is emitted afterwards.

Configuration
REQ-032 Macro SYSTOLIC_MAC_SAT_EN: when defined, each accumulate SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; when undefined, it wraps per REQ-028.

Verification (N_PE=4, DATA_W=16, ACC_W=40)
REQ-033 len=3, x=1,2,3, t[k][i]=i+1 -> out_data 6,12,18,24; out_last on 24; done the next cycle.
REQ-034 Same job as REQ-033 with in_valid low for 2 cycles between each beat -> identical 6,12,18,24.
REQ-035 REQ-033 job with out_ready low for 3 cycles while presenting 12 -> 12 held stable; sequence 6,12,18,24 with no loss or duplicate.
REQ-036 len=600, x=-32768, all t=-32768 -> with SYSTOLIC_MAC_SAT_EN all results 549755813887; without it all -455266533376.
REQ-037 reset after 2 of 3 beats, then len=1, x=5, all t=2 -> no output from the aborted job; then 10,10,10,10.
REQ-038 start with len=0 -> DRAIN directly; outputs 0,0,0,0 with out_last on the 4th; start pulsed during DRAIN is ignored.

Source files
------------

// File: rtl/systolic_mac_array.sv
// Linear systolic MAC chain: y[i] = sum_k x[k]*t[k][i], drained toward PE0.
// Define SYSTOLIC_MAC_SAT_EN for saturating accumulation (default wraps).
module systolic_mac_array #(
  parameter int N_PE   = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_x,
  input  logic [N_PE*DATA_W-1:0]   in_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_PE - 1);
  localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'((N_PE > 1) ? N_PE - 2 : 0);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   remain;
  logic [CNT_W-1:0]   cnt;
  logic               fire, take, advance;

  // x_pipe/v_pipe[d] and t_pipe[d][j] hold the beat delayed d+1 cycles
  logic signed [DATA_W-1:0] x_pipe [N_PE];
  logic                     v_pipe [N_PE];
  logic signed [DATA_W-1:0] t_pipe [N_PE][N_PE];
  logic signed [DATA_W-1:0] pe_x   [N_PE];
  logic signed [DATA_W-1:0] pe_t   [N_PE];
  logic                     pe_v   [N_PE];
  logic signed [ACC_W-1:0]  acc    [N_PE];

  function automatic logic signed [ACC_W-1:0] mac(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] t
  );
    logic signed [2*DATA_W-1:0] p;
    logic        [ACC_W:0]      s;
    p = (2*DATA_W)'(x) * (2*DATA_W)'(t);
    s = {a[ACC_W-1], a} + {{(ACC_W+1-2*DATA_W){p[2*DATA_W-1]}}, p};
`ifdef SYSTOLIC_MAC_SAT_EN
    if (s[ACC_W] != s[ACC_W-1])
      s[ACC_W-1:0] = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return s[ACC_W-1:0];
  endfunction

  assign fire    = in_valid & in_ready;
  assign take    = (state == IDLE) & start;
  assign advance = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len != '0) ? FEED : DRAIN;
      FEED:  if (fire && remain == LEN_W'(1)) state_nxt = (N_PE == 1) ? DRAIN : FLUSH;
      FLUSH: if (cnt == FLUSH_END) state_nxt = DRAIN;
      DRAIN: if (advance && cnt == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == FEED);
    busy      = (state != IDLE);
    out_valid = (state == DRAIN);
    out_last  = out_valid && (cnt == LAST_IDX);
    out_data  = out_valid ? acc[0] : '0;
  end

  // cnt times the flush in FLUSH and indexes results in DRAIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remain <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= advance && out_last;
      if (take)      remain <= len;
      else if (fire) remain <= remain - LEN_W'(1);
      if (state_nxt != state)            cnt <= '0;
      else if (state == FLUSH || advance) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_PE; i++) begin
      if (i == 0) begin
        pe_x[i] = in_x;
        pe_v[i] = fire;
        pe_t[i] = in_w[DATA_W-1:0];
      end else begin
        pe_x[i] = x_pipe[i-1];
        pe_v[i] = v_pipe[i-1];
        pe_t[i] = t_pipe[i-1][i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned d = 0; d < N_PE; d++) begin
        x_pipe[d] <= '0;
        v_pipe[d] <= 1'b0;
        acc[d]    <= '0;
        for (int unsigned j = 0; j < N_PE; j++) t_pipe[d][j] <= '0;
      end
    end else begin
      x_pipe[0] <= in_x;
      v_pipe[0] <= fire;
      for (int unsigned j = 1; j < N_PE; j++) t_pipe[0][j] <= in_w[j*DATA_W +: DATA_W];
      for (int unsigned d = 1; d + 1 < N_PE; d++) begin
        x_pipe[d] <= x_pipe[d-1];
        v_pipe[d] <= v_pipe[d-1];
        for (int unsigned j = d + 1; j < N_PE; j++) t_pipe[d][j] <= t_pipe[d-1][j];
      end
      if (take) begin
        for (int unsigned i = 0; i < N_PE; i++) acc[i] <= '0;
      end else if (advance) begin
        for (int unsigned i = 0; i + 1 < N_PE; i++) acc[i] <= acc[i+1];
        acc[N_PE-1] <= '0;
      end else begin
        for (int unsigned i = 0; i < N_PE; i++)
          if (pe_v[i]) acc[i] <= mac(acc[i], pe_x[i], pe_t[i]);
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Randomized and directed bench for systolic_mac_array against a sum-of-products model.
module tb_systolic_mac_array;
  localparam int N_PE = 4, DATA_W = 16, ACC_W = 40, LEN_W = 16;
  localparam longint ACC_MAX = 64'sd549755813887;
  localparam longint ACC_MIN = -64'sd549755813888;
`ifdef SYSTOLIC_MAC_SAT_EN
  localparam longint E36 = 64'sd549755813887;
`else
  localparam longint E36 = -64'sd455266533376;
`endif

  logic                   clk = 1'b0;
  logic                   reset, start, in_valid, out_ready;
  logic [LEN_W-1:0]       len;
  logic [DATA_W-1:0]      in_x;
  logic [N_PE*DATA_W-1:0] in_w;
  logic                   in_ready, out_valid, out_last, busy, done;
  logic [ACC_W-1:0]       out_data;

  systolic_mac_array #(.N_PE(N_PE), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  longint cyc = 0;
  longint got[$];
  int ready_ctl = 0, stall_at = 0, stall_cnt = 0;

  // model state
  logic signed [ACC_W-1:0] macc [N_PE];
  bit     mbusy = 0, expect_done = 0, prev_stall = 0;
  int     mK = 0, mk = 0, oidx = 0;
  longint drain_cyc = 0;
  logic [ACC_W-1:0] prev_data;
  logic   prev_last;

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic signed [ACC_W-1:0] step(logic signed [ACC_W-1:0] a, longint p);
    longint s;
    s = longint'(a) + p;
`ifdef SYSTOLIC_MAC_SAT_EN
    if (s > ACC_MAX) s = ACC_MAX;
    if (s < ACC_MIN) s = ACC_MIN;
`endif
    return s[ACC_W-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_ctl)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (out_valid && got.size() == stall_at && stall_cnt < 3) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else out_ready = 1'b1;
      end
    endcase
  end

  always @(negedge clk) begin : compare
    bit b0;
    if (reset) begin
      check("reset_outputs", longint'({in_ready, out_valid, out_last, busy, done, out_data != '0}), 0);
      mbusy = 0; mK = 0; mk = 0; expect_done = 0; prev_stall = 0;
    end else begin
      b0 = mbusy;
      check("busy", longint'(busy), longint'(mbusy));
      check("in_ready", longint'(in_ready), longint'(mbusy && mk < mK));
      check("out_valid", longint'(out_valid), longint'(mbusy && mk == mK && cyc >= drain_cyc));
      if (expect_done || done) check("done", longint'(done), longint'(expect_done));
      expect_done = 0;
      if (prev_stall) begin
        check("hold_data", longint'($signed(out_data)), longint'($signed(prev_data)));
        check("hold_last", longint'(out_last), longint'(prev_last));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (in_valid && in_ready && mk < mK) begin
        for (int i = 0; i < N_PE; i++)
          macc[i] = step(macc[i], longint'($signed(in_x)) * longint'($signed(in_w[i*DATA_W +: DATA_W])));
        mk++;
        if (mk == mK) drain_cyc = cyc + N_PE;
      end
      if (out_valid) begin
        if (mbusy && oidx < N_PE) begin
          check("out_data", longint'($signed(out_data)), longint'(macc[oidx]));
          check("out_last", longint'(out_last), longint'(oidx == N_PE - 1));
        end
        if (out_ready) begin
          got.push_back(longint'($signed(out_data)));
          if (mbusy) begin
            oidx++;
            if (oidx == N_PE) begin mbusy = 0; expect_done = 1; end
          end
        end
      end
      if (!b0 && start) begin
        mbusy = 1;
        for (int i = 0; i < N_PE; i++) macc[i] = '0;
        mK = int'(len); mk = 0; oidx = 0;
        drain_cyc = (len == '0) ? cyc + 1 : 64'sh7fff_ffff_ffff_ffff;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(int l);
    got.delete();
    start = 1'b1; len = LEN_W'(l);
    tick();
    start = 1'b0; len = LEN_W'($urandom);
  endtask

  task automatic feed(logic [DATA_W-1:0] x, logic [N_PE*DATA_W-1:0] w, int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_x = x; in_w = w; in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) check("feed_timeout", 0, 1);
    else tick();
    in_valid = 1'b0;
    in_x = DATA_W'($urandom);
    in_w = {$urandom, $urandom};
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    check("job_done", longint'(done), 1);
    tick();
  endtask

  task automatic check_got(string nm, input longint e [N_PE]);
    check({nm, "_count"}, got.size(), N_PE);
    for (int i = 0; i < N_PE; i++)
      if (i < got.size()) check(nm, got[i], e[i]);
  endtask

  localparam logic [N_PE*DATA_W-1:0] W_RAMP = {16'd4, 16'd3, 16'd2, 16'd1};

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // basic job
    start_job(3);
    for (int k = 1; k <= 3; k++) feed(DATA_W'(k), W_RAMP, 0);
    wait_done(50);
    check_got("basic", '{6, 12, 18, 24});

    // input bubbles
    start_job(3);
    for (int k = 1; k <= 3; k++) feed(DATA_W'(k), W_RAMP, 2);
    wait_done(50);
    check_got("bubbles", '{6, 12, 18, 24});

    // backpressure on the second result
    ready_ctl = 2; stall_at = 1; stall_cnt = 0;
    start_job(3);
    for (int k = 1; k <= 3; k++) feed(DATA_W'(k), W_RAMP, 0);
    wait_done(50);
    check_got("stall", '{6, 12, 18, 24});
    check("stall_cycles", stall_cnt, 3);

    // zero-length job with an ignored start during drain
    stall_at = 0; stall_cnt = 0;
    start_job(0);
    start = 1'b1; len = LEN_W'(5);
    tick();
    start = 1'b0;
    wait_done(50);
    check_got("len0", '{0, 0, 0, 0});
    repeat (5) tick();
    check("len0_idle", longint'(busy), 0);

    // abort mid-job
    ready_ctl = 0;
    start_job(3);
    feed(16'd1, W_RAMP, 0);
    feed(16'd2, W_RAMP, 0);
    reset = 1'b1;
    #1;
    check("reset_async", longint'({in_ready, out_valid, out_last, busy, done, out_data != '0}), 0);
    tick(); tick();
    reset = 1'b0;
    repeat (12) tick();
    check("abort_no_output", got.size(), 0);
    start_job(1);
    feed(16'd5, {4{16'd2}}, 0);
    wait_done(50);
    check_got("after_abort", '{10, 10, 10, 10});

    // long extreme job
    start_job(600);
    for (int k = 0; k < 600; k++) feed(16'h8000, {4{16'h8000}}, 0);
    wait_done(50);
    check_got("extreme", '{E36, E36, E36, E36});

    // randomized jobs
    ready_ctl = 1;
    for (int j = 0; j < 25; j++) begin
      int l;
      l = $urandom_range(0, 10);
      start_job(l);
      for (int k = 0; k < l; k++) feed(DATA_W'($urandom), {$urandom, $urandom}, $urandom_range(0, 2));
      wait_done(300);
      check("rand_count", got.size(), N_PE);
    end
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
